// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the async FIFO write port: grant follows req by 1 cycle, then 1 idle bubble after each burst.
// wfull stalls the owner but keeps its grant. Define FIFO_WR_ARB_PRIO0_EN to make requester 0 win every idle arbitration.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     winc,
    output logic [WIDTH-1:0]         wdata,
    input  logic                     wfull
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_owner;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             accept;
    logic             burst_end;
    logic [WIDTH-1:0] data_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Scan backwards and overwrite so the first set request after last_owner wins.
    always_comb begin
        winner = last_owner;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            if (req[cand]) begin
                winner = cand;
            end
        end
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (req[0]) begin
            winner = '0;
        end
`endif
    end

    always_comb begin
        accept    = (state == BURST) && req[owner] && !wfull;
        burst_end = accept && (req_last[owner] || (count == CNT_W'(MAX_BURST - 1)));
        winc      = accept;
        ack       = '0;
        if (accept) begin
            ack[owner] = 1'b1;
        end
        wdata = (state == BURST) ? data_arr[owner] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= BURST;
                        gnt   <= NUM_REQ'(1) << winner;
                        owner <= winner;
                        count <= '0;
                    end
                end
                BURST: begin
                    if (!req[owner] || burst_end) begin
                        state      <= IDLE;
                        gnt        <= '0;
                        last_owner <= owner;
                        count      <= '0;
                    end else if (accept) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    a_no_write_when_full: assert property (@(posedge clk) disable iff (rst) !(winc && wfull));
    a_gnt_onehot0:        assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with random data plus a randomized run against a rule-level model.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 8;
    localparam int IW        = 2;
    localparam int OW        = 2*NUM_REQ + 1 + WIDTH;

    logic                     clk   = 1'b0;
    logic                     rst   = 1'b1;
    logic                     wfull = 1'b0;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       ack;
    logic                     winc;
    logic [WIDTH-1:0]         wdata;

    int checks   = 0;
    int failures = 0;

    int               src_left   [NUM_REQ];
    bit               src_nolast [NUM_REQ];
    logic [WIDTH-1:0] src_word   [NUM_REQ];
    logic [NUM_REQ-1:0] ack_s;
    logic [OW-1:0]    obs;
    logic [OW-1:0]    exp_v;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH    (WIDTH),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .req_last(req_last),
        .gnt     (gnt),
        .ack     (ack),
        .winc    (winc),
        .wdata   (wdata),
        .wfull   (wfull)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_src
        assign req[g]                     = src_left[g] > 0;
        assign req_last[g]                = !src_nolast[g] && (src_left[g] == 1);
        assign req_data[g*WIDTH +: WIDTH] = src_word[g];
    end

    assign obs = {gnt, ack, winc, wdata};

    // Expected {gnt, ack, winc, wdata} for a given owner (-1 = idle) and accept decision.
    function automatic logic [OW-1:0] expect_at(int owner, bit acc);
        logic [NUM_REQ-1:0] g;
        logic [WIDTH-1:0]   d;
        g = '0;
        d = '0;
        if (owner >= 0) begin
            g = NUM_REQ'(1) << owner;
            d = src_word[owner];
        end
        return {g, acc ? g : {NUM_REQ{1'b0}}, acc, d};
    endfunction

    function automatic int rr_pick(logic [NUM_REQ-1:0] r, int last);
        int w;
        w = -1;
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (w < 0 && r[IW'((last + k) % NUM_REQ)]) w = (last + k) % NUM_REQ;
        end
        return w;
    endfunction

    task automatic next_cycle();
        ack_s = ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_s[IW'(i)]) begin
                src_left[i] = src_left[i] - 1;
                src_word[i] = $urandom;
            end
        end
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        wfull = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_left[i]   = 0;
            src_nolast[i] = 1'b0;
            src_word[i]   = $urandom;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        wfull = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_left[i]   = 5;
            src_nolast[i] = 1'b0;
            src_word[i]   = $urandom;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d got=%h expected=%h", c, obs, {OW{1'b0}});
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) src_left[i] = 0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_release got=%h expected=%h", obs, {OW{1'b0}});
        end
        next_cycle();
    endtask

    task automatic test_single_burst();
        apply_reset();
        src_left[0] = 3;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_v = (c >= 1 && c <= 3) ? expect_at(0, 1'b1) : expect_at(-1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL single_burst cycle=%0d got=%h expected=%h", c, obs, exp_v);
            end
            next_cycle();
        end
        checks++;
        if (src_left[0] !== 0) begin
            failures++;
            $display("FAIL single_burst_words_left got=%0d expected=0", src_left[0]);
        end
    endtask

    task automatic test_round_robin();
        int o;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_left[i]   = 1000;
            src_nolast[i] = 1'b1;
        end
        for (int b = 0; b < NUM_REQ + 1; b++) begin
            o = b % NUM_REQ;
            @(negedge clk);
            exp_v = expect_at(-1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL rr_bubble burst=%0d got=%h expected=%h", b, obs, exp_v);
            end
            next_cycle();
            for (int w = 0; w < MAX_BURST; w++) begin
                @(negedge clk);
                exp_v = expect_at(o, 1'b1);
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL rr_word burst=%0d word=%0d got=%h expected=%h", b, w, obs, exp_v);
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_stall();
        int stall_at = $urandom_range(1, 6);
        apply_reset();
        src_left[2]   = 1000;
        src_nolast[2] = 1'b1;
        @(negedge clk);
        exp_v = expect_at(-1, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL stall_idle got=%h expected=%h", obs, exp_v);
        end
        next_cycle();
        for (int w = 0; w < MAX_BURST; w++) begin
            if (w == stall_at) begin
                wfull = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    exp_v = expect_at(2, 1'b0);
                    checks++;
                    if (obs !== exp_v) begin
                        failures++;
                        $display("FAIL stall_hold cycle=%0d got=%h expected=%h", s, obs, exp_v);
                    end
                    next_cycle();
                end
                wfull = 1'b0;
            end
            @(negedge clk);
            exp_v = expect_at(2, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL stall_word word=%0d got=%h expected=%h", w, obs, exp_v);
            end
            next_cycle();
        end
        @(negedge clk);
        exp_v = expect_at(-1, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL stall_bubble got=%h expected=%h", obs, exp_v);
        end
        next_cycle();
        @(negedge clk);
        exp_v = expect_at(2, 1'b1);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL stall_regrant got=%h expected=%h", obs, exp_v);
        end
        next_cycle();
    endtask

    task automatic test_drop();
        int n = $urandom_range(1, 6);
        apply_reset();
        src_left[1] = 1000; src_nolast[1] = 1'b1;
        src_left[2] = 1000; src_nolast[2] = 1'b1;
        @(negedge clk);
        exp_v = expect_at(-1, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL drop_idle got=%h expected=%h", obs, exp_v);
        end
        next_cycle();
        for (int w = 0; w < n; w++) begin
            @(negedge clk);
            exp_v = expect_at(1, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL drop_word word=%0d got=%h expected=%h", w, obs, exp_v);
            end
            next_cycle();
        end
        src_left[1] = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_v = (c == 0) ? expect_at(1, 1'b0) : (c == 1) ? expect_at(-1, 1'b0) : expect_at(2, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL drop_after cycle=%0d got=%h expected=%h", c, obs, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_burst();
        int r = $urandom_range(1, 3);
        apply_reset();
        src_left[r]   = 1000;
        src_nolast[r] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_v = (c == 0) ? expect_at(-1, 1'b0) : expect_at(r, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL rstmid_pre cycle=%0d got=%h expected=%h", c, obs, exp_v);
            end
            next_cycle();
        end
        #1;
        exp_v = expect_at(r, 1'b1);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL rstmid_word4 got=%h expected=%h", obs, exp_v);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL rstmid_async got=%h expected=%h", obs, {OW{1'b0}});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_left[i]   = 1000;
            src_nolast[i] = 1'b1;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            exp_v = (c == 0) ? expect_at(-1, 1'b0) : expect_at(0, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL rstmid_regrant cycle=%0d got=%h expected=%h", c, obs, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_prio0();
        int winner;
`ifdef FIFO_WR_ARB_PRIO0_EN
        winner = 0;
`else
        winner = 2;
`endif
        apply_reset();
        src_left[1] = 4;    src_nolast[1] = 1'b0;
        src_left[2] = 1000; src_nolast[2] = 1'b1;
        src_left[3] = 1000; src_nolast[3] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 3) begin
                src_left[0]   = 1000;
                src_nolast[0] = 1'b1;
            end
            @(negedge clk);
            exp_v = (c == 0 || c == 5) ? expect_at(-1, 1'b0) : (c == 6) ? expect_at(winner, 1'b1) : expect_at(1, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL prio0 cycle=%0d got=%h expected=%h", c, obs, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        int m_owner = -1;
        int m_last  = NUM_REQ - 1;
        int m_words = 0;
        bit acc;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_left[i] == 0 && $urandom_range(0, 3) == 0) begin
                    src_left[i]   = $urandom_range(1, 12);
                    src_nolast[i] = ($urandom_range(0, 3) == 0);
                end
            end
            wfull = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            acc   = (m_owner >= 0) && req[IW'(m_owner)] && !wfull;
            exp_v = expect_at(m_owner, acc);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random cycle=%0d got=%h expected=%h", c, obs, exp_v);
            end
            if (m_owner < 0) begin
                if (req != '0) begin
                    m_owner = rr_pick(req, m_last);
                    m_words = 0;
                end
            end else if (!req[IW'(m_owner)]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (acc) begin
                m_words++;
                if (req_last[IW'(m_owner)] || m_words == MAX_BURST) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
            next_cycle();
        end
        wfull = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_stall();
        test_drop();
        test_reset_mid_burst();
        test_prio0();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end

endmodule
